framebuffer_scanout: RTL and testbench

- Read-side master of the dual-port framebuffer RAM: generates VGA timing, drives the RAM read address, and turns returned 12-bit RGB444 words into pixel/sync outputs for the RAMDAC pins.
- Framebuffer is stored downscaled; each stored pixel covers a 2^SCALE_SHIFT x 2^SCALE_SHIFT screen block.
- Sits between the framebuffer RAM read port (same clock as read_clock) and the top-level video outputs.

---
 rtl/framebuffer_scanout_if.sv | 14 +
 rtl/framebuffer_scanout.sv | 135 +++++++++++++
 tb/tb_framebuffer_scanout.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer RAM read-port bundle.
//   read_address : address presented to the RAM (driven by the scanout master)
//   ram_data     : RAM output word, valid one clock after read_address
// Modports: master = scanout side, slave = RAM side.
interface framebuffer_scanout_if #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned ADDRESS_SIZE = 13
);
  logic [ADDRESS_SIZE-1:0] read_address;
  logic [DATA_WIDTH-1:0]   ram_data;

  modport master (output read_address, input ram_data);
  modport slave  (input read_address, output ram_data);
endinterface

// File: rtl/framebuffer_scanout.sv
// VGA scanout engine for a downscaled RGB444 framebuffer.
// Generates VGA timing, drives the framebuffer read address, and converts the
// returned words into registered colour and sync outputs. Every output lags
// the timing counters by exactly three clocks.
//   clock, reset      : pixel clock, synchronous active-high reset
//   enable            : low holds the timing at the origin with idle outputs
//   ram               : RAM read port (read_address out, ram_data in)
//   red, green, blue  : registered 4-bit colour, zero outside the visible area
//   hsync, vsync      : active-low syncs
//   blank             : high outside the visible area
//   frame_start       : one-cycle pulse with the first visible pixel of a frame
module framebuffer_scanout #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned ADDRESS_SIZE = 13,
  parameter int unsigned SCALE_SHIFT  = 3,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  framebuffer_scanout_if.master ram,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FB_WIDTH = H_VISIBLE >> SCALE_SHIFT;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HVis       = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncStart = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VVis       = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncStart = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  // Low bits of v that must be zero for a new framebuffer row to begin.
  localparam logic [VW-1:0] VRowMask   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDRESS_SIZE-1:0] FbStride = ADDRESS_SIZE'(FB_WIDTH);

  // Per-pixel control carried alongside the data through the pipeline.
  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic fs;
  } ctl_t;

  localparam ctl_t CtlIdle = ctl_t'(4'b0110);

  logic [HW-1:0]           h_q, h_d;
  logic [VW-1:0]           v_q, v_d, v_next;
  logic [ADDRESS_SIZE-1:0] line_base_q, line_base_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  ctl_t                    ctl1_q, ctl1_d, ctl2_q, ctl3_q;
  logic [11:0]             rgb_q, rgb_d;

  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    line_base_d = line_base_q;
    v_next      = (v_q == VLast) ? '0 : v_q + 1'b1;

    if (h_q == HLast) begin
      h_d = '0;
      v_d = v_next;
      // Row base advances by one framebuffer row every 2^SCALE_SHIFT lines,
      // avoiding a multiplier on the address path.
      if (v_next == '0) begin
        line_base_d = '0;
      end else if ((v_next < VVis) && ((v_next & VRowMask) == '0)) begin
        line_base_d = line_base_q + FbStride;
      end
    end else begin
      h_d = h_q + 1'b1;
    end

    ctl1_d.vis  = (h_q < HVis) && (v_q < VVis);
    ctl1_d.hs_n = !((h_q >= HSyncStart) && (h_q <= HSyncEnd));
    ctl1_d.vs_n = !((v_q >= VSyncStart) && (v_q <= VSyncEnd));
    ctl1_d.fs   = (h_q == '0) && (v_q == '0);

    addr_d = ctl1_d.vis ? line_base_q + ADDRESS_SIZE'(h_q >> SCALE_SHIFT) : addr_q;

    // Gating on the delayed visible flag also hides stale RAM data after a restart.
    rgb_d = ctl2_q.vis ? ram.ram_data[DATA_WIDTH-1 -: 12] : 12'h000;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= '0;
      addr_q      <= '0;
      ctl1_q      <= CtlIdle;
      ctl2_q      <= CtlIdle;
      ctl3_q      <= CtlIdle;
      rgb_q       <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      ctl1_q      <= ctl1_d;
      ctl2_q      <= ctl1_q;
      ctl3_q      <= ctl2_q;
      rgb_q       <= rgb_d;
    end
  end

  assign ram.read_address = addr_q;
  assign red              = rgb_q[11:8];
  assign green            = rgb_q[7:4];
  assign blue             = rgb_q[3:0];
  assign hsync            = ctl3_q.hs_n;
  assign vsync            = ctl3_q.vs_n;
  assign blank            = !ctl3_q.vis;
  assign frame_start      = ctl3_q.fs;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Three scanout instances share clock, reset and enable: a small-timing one
// that wraps many frames, the SCALE_SHIFT=2 / 320x240 override, and the default
// 640x480 build. A RAM model full of random words feeds each one. The reference
// model derives every expected output from the number of enabled cycles since
// the last reset/disable, using plain arithmetic on the timing parameters.
module tb_framebuffer_scanout;

  localparam int NDUT = 3;
  localparam int HV [NDUT] = '{64, 320, 640};
  localparam int HF [NDUT] = '{4, 16, 16};
  localparam int HS [NDUT] = '{8, 96, 96};
  localparam int HT [NDUT] = '{80, 480, 800};
  localparam int VV [NDUT] = '{48, 240, 480};
  localparam int VF [NDUT] = '{2, 10, 10};
  localparam int VS [NDUT] = '{2, 2, 2};
  localparam int VT [NDUT] = '{55, 285, 525};
  localparam int SH [NDUT] = '{3, 2, 3};

  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  logic [11:0] mem [8192];

  framebuffer_scanout_if #(.DATA_WIDTH(12), .ADDRESS_SIZE(13)) ram_a ();
  framebuffer_scanout_if #(.DATA_WIDTH(12), .ADDRESS_SIZE(13)) ram_b ();
  framebuffer_scanout_if #(.DATA_WIDTH(12), .ADDRESS_SIZE(13)) ram_c ();

  // Synchronous-read RAM models: word valid one clock after the address.
  always @(posedge clk) ram_a.ram_data <= mem[ram_a.read_address];
  always @(posedge clk) ram_b.ram_data <= mem[ram_b.read_address];
  always @(posedge clk) ram_c.ram_data <= mem[ram_c.read_address];

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b, hs_c, vs_c, bl_c, fs_c;

  framebuffer_scanout #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_dut_a (
    .clock(clk), .reset(reset), .enable(enable), .ram(ram_a),
    .red(r_a), .green(g_a), .blue(b_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .frame_start(fs_a)
  );

  framebuffer_scanout #(
    .SCALE_SHIFT(2), .H_VISIBLE(320), .V_VISIBLE(240)
  ) u_dut_b (
    .clock(clk), .reset(reset), .enable(enable), .ram(ram_b),
    .red(r_b), .green(g_b), .blue(b_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_start(fs_b)
  );

  framebuffer_scanout u_dut_c (
    .clock(clk), .reset(reset), .enable(enable), .ram(ram_c),
    .red(r_c), .green(g_c), .blue(b_c),
    .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .frame_start(fs_c)
  );

  logic [11:0] got_rgb  [NDUT];
  logic [3:0]  got_ctl  [NDUT];
  logic [12:0] got_addr [NDUT];

  assign got_rgb[0]  = {r_a, g_a, b_a};
  assign got_rgb[1]  = {r_b, g_b, b_b};
  assign got_rgb[2]  = {r_c, g_c, b_c};
  assign got_ctl[0]  = {hs_a, vs_a, bl_a, fs_a};
  assign got_ctl[1]  = {hs_b, vs_b, bl_b, fs_b};
  assign got_ctl[2]  = {hs_c, vs_c, bl_c, fs_c};
  assign got_addr[0] = ram_a.read_address;
  assign got_addr[1] = ram_b.read_address;
  assign got_addr[2] = ram_c.read_address;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int h_at(int d, int k);
    return k % HT[d];
  endfunction

  function automatic int v_at(int d, int k);
    return (k / HT[d]) % VT[d];
  endfunction

  function automatic bit vis_at(int d, int k);
    return (h_at(d, k) < HV[d]) && (v_at(d, k) < VV[d]);
  endfunction

  // Framebuffer word shown at screen position (h, v).
  function automatic int addr_at(int d, int k);
    return (v_at(d, k) >> SH[d]) * (HV[d] >> SH[d]) + (h_at(d, k) >> SH[d]);
  endfunction

  // {hsync, vsync, blank, frame_start} for counter index k.
  function automatic logic [3:0] ctl_at(int d, int k);
    int h;
    int v;
    logic hs_n;
    logic vs_n;
    h = h_at(d, k);
    v = v_at(d, k);
    hs_n = !((h >= HV[d] + HF[d]) && (h < HV[d] + HF[d] + HS[d]));
    vs_n = !((v >= VV[d] + VF[d]) && (v < VV[d] + VF[d] + VS[d]));
    return {hs_n, vs_n, !vis_at(d, k), (k % (HT[d] * VT[d])) == 0};
  endfunction

  // m: enabled clock edges since the last reset/disable edge.
  // exp_addr: address of the most recent visible counter value, 0 after a clear.
  int m        [NDUT] = '{0, 0, 0};
  int exp_addr [NDUT] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (reset || !enable) begin
        m[d]        <= 0;
        exp_addr[d] <= 0;
      end else begin
        if (vis_at(d, m[d])) exp_addr[d] <= addr_at(d, m[d]);
        m[d] <= m[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < NDUT; d++) begin
        int k;
        logic [11:0] er;
        logic [3:0]  ec;
        k = m[d] - 3;
        if (k < 0) begin
          er = 12'h000;
          ec = 4'b1110;
        end else begin
          er = vis_at(d, k) ? mem[addr_at(d, k)] : 12'h000;
          ec = ctl_at(d, k);
        end
        check_eq($sformatf("rgb dut%0d m=%0d", d, m[d]), 32'(got_rgb[d]), 32'(er));
        check_eq($sformatf("sync dut%0d m=%0d", d, m[d]), 32'(got_ctl[d]), 32'(ec));
        check_eq($sformatf("addr dut%0d m=%0d", d, m[d]), 32'(got_addr[d]), 32'(exp_addr[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;

    // Long undisturbed run: several small frames, early lines of the big builds.
    repeat (20000) @(negedge clk);

    // Random mid-frame disturbances.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(300, 2500)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin
          reset = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          reset = 1'b0;
        end
        1: begin
          enable = 1'b0;
          repeat (5) @(negedge clk);
          enable = 1'b1;
        end
        default: begin
          enable = 1'b0;
          reset  = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          reset  = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          enable = 1'b1;
        end
      endcase
    end

    repeat (9000) @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
